// File: rtl/ide_pkg.sv
// Shared types and constants for the Gayle-compatible IDE controller.
package ide_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [7:0] IDE_BASE_DEF = 8'hDA;

  // Gayle register offsets within A[14:12]
  localparam logic [SEL_W-1:0] REG_STATUS = 3'd0;
  localparam logic [SEL_W-1:0] REG_INTREQ = 3'd1;
  localparam logic [SEL_W-1:0] REG_INTENA = 3'd2;

  // IRQ flag position in every Gayle register
  localparam int unsigned IRQ_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_REGACK = 3'd4,
    ST_ACK    = 3'd5,
    ST_WAITAS = 3'd6
  } state_t;

  // Bus-cycle attributes captured at decode
  typedef struct packed {
    logic             is_reg;
    logic [SEL_W-1:0] sel;
    logic             cs1;
    logic             rd;
  } cyc_t;

endpackage

// File: rtl/ide_gayle_regs.sv
// Gayle interrupt status/request/enable registers and INT2 request.
module gayle_regs
  import ide_pkg::*;
(
  input  logic              CLKCPU,
  input  logic              RESET,
  input  logic              IDEINT,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              irq_c
);

  logic ideint_q;
  logic ideint_qq;
  logic intreq;
  logic intena;
  logic ideint_rise;
  logic unused_wr;

  assign ideint_rise = ideint_q & ~ideint_qq;
  assign unused_wr   = ^wr_data[IRQ_BIT-1:0];

  // IDEINT sampling, INTREQ set/clear (set dominates), INTENA write
  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      ideint_q  <= 1'b0;
      ideint_qq <= 1'b0;
      intreq    <= 1'b0;
      intena    <= 1'b0;
    end else begin
      ideint_q  <= IDEINT;
      ideint_qq <= ideint_q;
      if (ideint_rise)
        intreq <= 1'b1;
      else if (wr_en && reg_sel == REG_INTREQ && !wr_data[IRQ_BIT])
        intreq <= 1'b0;
      if (wr_en && reg_sel == REG_INTENA)
        intena <= wr_data[IRQ_BIT];
    end
  end

  // Register read mux; unmapped offsets read as zero
  always_comb begin
    rd_data_c = '0;
    case (reg_sel)
      REG_STATUS: rd_data_c[IRQ_BIT] = ideint_q;
      REG_INTREQ: rd_data_c[IRQ_BIT] = intreq;
      REG_INTENA: rd_data_c[IRQ_BIT] = intena;
      default:    rd_data_c = '0;
    endcase
  end

  assign irq_c = intreq & intena;

endmodule

// File: rtl/ide_ctrl.sv
// IDE cycle controller: decode, PIO-timed strobes, port-size acknowledge.
module ide_ctrl
  import ide_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 6,
  parameter int unsigned HOLD_CYC   = 2,
  parameter logic [7:0]  IDE_BASE   = IDE_BASE_DEF
) (
  input  logic              CLKCPU,
  input  logic              RESET,
  input  logic [23:0]       A,
  inout  wire  [DATA_W-1:0] D,
  input  logic              AS20,
  input  logic              RW20,
  input  logic              IDEINT,
  output wire               INT2,
  output logic              IOR,
  output logic              IOW,
  output logic [1:0]        IDECS,
  output logic              IDE_ACCESS,
  output logic              ACK16_N,
  output logic              ACK8_N
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cyc_t               cyc_q, cyc_d;
  logic               access_q;
  logic               access_rise;
  logic               ior_d, iow_d, ack16_d, ack8_d;
  logic [1:0]         idecs_d;
  logic               reg_wr;
  logic               d_oe;
  logic [DATA_W-1:0]  rd_data;
  logic               irq;
  logic               unused_a;

  assign unused_a    = ^A[11:0];
  assign IDE_ACCESS  = ~AS20 & (A[23:16] == IDE_BASE);
  assign access_rise = IDE_ACCESS & ~access_q;

  // State, counter, captured cycle and registered outputs
  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cyc_q    <= '0;
      access_q <= 1'b0;
      IOR      <= 1'b1;
      IOW      <= 1'b1;
      IDECS    <= 2'b11;
      ACK16_N  <= 1'b1;
      ACK8_N   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      access_q <= IDE_ACCESS;
      IOR      <= ior_d;
      IOW      <= iow_d;
      IDECS    <= idecs_d;
      ACK16_N  <= ack16_d;
      ACK8_N   <= ack8_d;
    end
  end

  // Next state, counter reload and cycle capture
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (access_rise) begin
          cyc_d = '{is_reg: A[15], sel: A[14:12], cs1: A[13], rd: RW20};
          if (A[15]) begin
            state_d = ST_REGACK;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      ST_SETUP: begin
        if (AS20) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (AS20) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (AS20 || !cyc_q.is_reg) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          state_d = ST_WAITAS;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_WAITAS;
      end
      ST_REGACK: state_d = ST_ACK;
      ST_WAITAS: begin
        if (AS20) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state, registered on the same edge
  always_comb begin
    ior_d   = 1'b1;
    iow_d   = 1'b1;
    idecs_d = 2'b11;
    ack16_d = 1'b1;
    ack8_d  = 1'b1;
    if (!cyc_d.is_reg) begin
      if (state_d inside {ST_SETUP, ST_STROBE, ST_ACK, ST_HOLD})
        idecs_d = cyc_d.cs1 ? 2'b01 : 2'b10;
      if (state_d inside {ST_STROBE, ST_ACK}) begin
        if (cyc_d.rd) ior_d = 1'b0;
        else          iow_d = 1'b0;
      end
      if (state_d == ST_ACK) ack16_d = 1'b0;
    end else if (state_d == ST_ACK) begin
      ack8_d = 1'b0;
    end
  end

  assign reg_wr = (state_q == ST_REGACK) & cyc_q.is_reg & ~cyc_q.rd;
  assign d_oe   = cyc_q.is_reg & cyc_q.rd &
                  (state_q inside {ST_REGACK, ST_ACK, ST_WAITAS});

  assign D    = d_oe ? rd_data : {DATA_W{1'bz}};
  assign INT2 = irq ? 1'b0 : 1'bz;

  gayle_regs u_gayle_regs (
    .CLKCPU    (CLKCPU),
    .RESET     (RESET),
    .IDEINT    (IDEINT),
    .wr_en     (reg_wr),
    .reg_sel   (cyc_q.sel),
    .wr_data   (D),
    .rd_data_c (rd_data),
    .irq_c     (irq)
  );

endmodule

// File: tb/tb_ide_ctrl.sv
// Directed bench for ide_ctrl with an acknowledge scoreboard.
module tb_ide_ctrl;

  logic        CLKCPU = 1'b0;
  logic        RESET;
  logic [23:0] A;
  wire  [7:0]  D;
  logic        AS20;
  logic        RW20;
  logic        IDEINT;
  wire         INT2;
  logic        IOR, IOW, IDE_ACCESS, ACK16_N, ACK8_N;
  logic [1:0]  IDECS;

  logic       tb_d_oe;
  logic [7:0] tb_d;

  assign D = tb_d_oe ? tb_d : 8'bz;
  pullup (INT2);

  always #5 CLKCPU = ~CLKCPU;

  ide_ctrl dut (
    .CLKCPU     (CLKCPU),
    .RESET      (RESET),
    .A          (A),
    .D          (D),
    .AS20       (AS20),
    .RW20       (RW20),
    .IDEINT     (IDEINT),
    .INT2       (INT2),
    .IOR        (IOR),
    .IOW        (IOW),
    .IDECS      (IDECS),
    .IDE_ACCESS (IDE_ACCESS),
    .ACK16_N    (ACK16_N),
    .ACK8_N     (ACK8_N)
  );

  typedef struct {
    logic       ack16_n;
    logic       ack8_n;
    logic [1:0] idecs;
    logic       ior;
    logic       iow;
    logic       chk_d;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [1:0] rec_cs  [1:16];
  logic       rec_ior [1:16];
  logic       rec_iow [1:16];
  logic       rec_ack [1:16];
  logic       int2_commit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKCPU);
    #1;
  endtask

  // Monitor: every acknowledge must match the oldest expected transfer
  always @(negedge CLKCPU) begin
    if (RESET === 1'b1 && (ACK16_N === 1'b0 || ACK8_N === 1'b0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, ACK16_N, ACK8_N}, 32'd3);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack16_n", 32'(ACK16_N), 32'(e.ack16_n));
        chk("ack8_n",  32'(ACK8_N),  32'(e.ack8_n));
        chk("ack_idecs", 32'(IDECS), 32'(e.idecs));
        chk("ack_ior", 32'(IOR), 32'(e.ior));
        chk("ack_iow", 32'(IOW), 32'(e.iow));
        if (e.chk_d) chk("read_data", 32'(D), 32'(e.d));
      end
    end
  end

  // Task-file cycle; AS20 is released after abort_at (or after n edges)
  task automatic tf_run(input logic [23:0] addr, input logic rw, input int n, input int abort_at);
    A = addr; RW20 = rw; AS20 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      rec_cs[k] = IDECS; rec_ior[k] = IOR; rec_iow[k] = IOW; rec_ack[k] = ACK16_N;
      if (k == abort_at) AS20 = 1'b1;
    end
    AS20 = 1'b1;
    tick(); tick();
  endtask

  // Gayle register cycle; optionally raises IDEINT at the same moment
  task automatic reg_cycle(input logic [23:0] addr, input logic rw, input logic [7:0] wd,
                           input logic [7:0] exp_d, input logic raise_int);
    exp_t e;
    e = '{ack16_n: 1'b1, ack8_n: 1'b0, idecs: 2'b11, ior: 1'b1, iow: 1'b1, chk_d: rw, d: exp_d};
    sb.push_back(e);
    A = addr; RW20 = rw; tb_d = wd; tb_d_oe = ~rw; AS20 = 1'b0;
    if (raise_int) IDEINT = 1'b1;
    tick(); tick();
    int2_commit = INT2;
    tick(); tick();
    AS20 = 1'b1; tb_d_oe = 1'b0;
    tick(); tick();
  endtask

  initial begin
    exp_t e;
    int   n_ior, n_iow;
    RESET = 1'b0; A = '0; AS20 = 1'b1; RW20 = 1'b1; IDEINT = 1'b0;
    tb_d_oe = 1'b0; tb_d = '0;
    tick(); tick(); tick();
    chk("rst_ior", 32'(IOR), 32'd1);
    chk("rst_iow", 32'(IOW), 32'd1);
    chk("rst_idecs", 32'(IDECS), 32'd3);
    chk("rst_ack16", 32'(ACK16_N), 32'd1);
    chk("rst_ack8", 32'(ACK8_N), 32'd1);
    chk("rst_int2", 32'(INT2), 32'd1);
    RESET = 1'b1;
    tick();
    reg_cycle(24'hDAA000, 1'b1, 8'h00, 8'h00, 1'b0);

    // Task-file read $DA0004 with default timing
    e = '{ack16_n: 1'b0, ack8_n: 1'b1, idecs: 2'b10, ior: 1'b0, iow: 1'b1, chk_d: 1'b0, d: 8'h00};
    sb.push_back(e);
    tf_run(24'hDA0004, 1'b1, 13, 0);
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("rd_idecs_e%0d", k), 32'(rec_cs[k]), (k <= 11) ? 32'd2 : 32'd3);
      chk($sformatf("rd_ior_e%0d", k), 32'(rec_ior[k]), (k >= 3 && k <= 9) ? 32'd0 : 32'd1);
      chk($sformatf("rd_ack16_e%0d", k), 32'(rec_ack[k]), (k == 9) ? 32'd0 : 32'd1);
      chk($sformatf("rd_iow_e%0d", k), 32'(rec_iow[k]), 32'd1);
    end

    // Task-file write $DA2018 selects CS1
    e = '{ack16_n: 1'b0, ack8_n: 1'b1, idecs: 2'b01, ior: 1'b1, iow: 1'b0, chk_d: 1'b0, d: 8'h00};
    sb.push_back(e);
    tf_run(24'hDA2018, 1'b0, 13, 0);
    n_ior = 0; n_iow = 0;
    for (int k = 1; k <= 13; k++) begin
      if (rec_ior[k] == 1'b0) n_ior++;
      if (rec_iow[k] == 1'b0) n_iow++;
    end
    chk("wr_idecs_e1", 32'(rec_cs[1]), 32'd1);
    chk("wr_iow_width", 32'(n_iow), 32'd7);
    chk("wr_ior_width", 32'(n_ior), 32'd0);
    chk("wr_ack16_e9", 32'(rec_ack[9]), 32'd0);

    // Abort two cycles into STROBE: no ack, hold still honoured
    tf_run(24'hDA0004, 1'b1, 9, 4);
    chk("ab_ior_e4", 32'(rec_ior[4]), 32'd0);
    chk("ab_ior_e5", 32'(rec_ior[5]), 32'd1);
    chk("ab_idecs_e6", 32'(rec_cs[6]), 32'd2);
    chk("ab_idecs_e7", 32'(rec_cs[7]), 32'd3);
    for (int k = 1; k <= 9; k++)
      chk($sformatf("ab_ack16_e%0d", k), 32'(rec_ack[k]), 32'd1);

    // Interrupt path
    reg_cycle(24'hDAA000, 1'b0, 8'h80, 8'h00, 1'b0);
    chk("int2_ena_only", 32'(INT2), 32'd1);
    IDEINT = 1'b1;
    tick(); tick(); tick(); tick();
    chk("int2_asserted", 32'(INT2), 32'd0);
    reg_cycle(24'hDA8000, 1'b1, 8'h00, 8'h80, 1'b0);
    reg_cycle(24'hDA9000, 1'b1, 8'h00, 8'h80, 1'b0);
    reg_cycle(24'hDA9000, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("int2_clear_commit", 32'(int2_commit), 32'd1);
    reg_cycle(24'hDA9000, 1'b1, 8'h00, 8'h00, 1'b0);
    reg_cycle(24'hDA9000, 1'b0, 8'h80, 8'h00, 1'b0);
    reg_cycle(24'hDA9000, 1'b1, 8'h00, 8'h00, 1'b0);
    reg_cycle(24'hDAB000, 1'b0, 8'hFF, 8'h00, 1'b0);
    reg_cycle(24'hDAB000, 1'b1, 8'h00, 8'h00, 1'b0);
    reg_cycle(24'hDAA000, 1'b1, 8'h00, 8'h80, 1'b0);

    // Set INTREQ, then clear it on the same edge as a new IDEINT rise
    IDEINT = 1'b0; tick(); tick(); tick();
    IDEINT = 1'b1; tick(); tick(); tick();
    IDEINT = 1'b0; tick(); tick(); tick();
    chk("int2_reset_again", 32'(INT2), 32'd0);
    reg_cycle(24'hDA9000, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("int2_set_wins", 32'(INT2), 32'd0);
    reg_cycle(24'hDA9000, 1'b1, 8'h00, 8'h80, 1'b0);

    // Reset in the middle of STROBE
    A = 24'hDA0004; RW20 = 1'b1; AS20 = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("pre_rst_ior", 32'(IOR), 32'd0);
    RESET = 1'b0;
    tick();
    chk("mid_rst_ior", 32'(IOR), 32'd1);
    chk("mid_rst_iow", 32'(IOW), 32'd1);
    chk("mid_rst_idecs", 32'(IDECS), 32'd3);
    chk("mid_rst_ack16", 32'(ACK16_N), 32'd1);
    chk("mid_rst_ack8", 32'(ACK8_N), 32'd1);
    chk("mid_rst_int2", 32'(INT2), 32'd1);
    RESET = 1'b1; AS20 = 1'b1;
    tick(); tick();
    reg_cycle(24'hDAA000, 1'b1, 8'h00, 8'h00, 1'b0);

    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
